// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Round-robin grant over a valid/ready request handshake, one registered
//   output stage returning the result to the granted port with its own
//   valid/ready handshake. Adds exactly one cycle of latency.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   req_valid_i[1:0]  per-port request valid
//   req_ready_o[1:0]  per-port request accepted (combinational grant)
//   req_operand_a_i   packed operand A, port r in [r*WORD_WIDTH +: WORD_WIDTH]
//   req_operand_b_i   packed operand B, same packing
//   req_operator_i    packed ALU operator, port r in [r*ALU_OP_WIDTH +: ALU_OP_WIDTH]
//   rsp_valid_o[1:0]  result held for port r (registered)
//   rsp_ready_i[1:0]  port r consumes its result
//   rsp_result_o      stored result, shared by both ports
// Also contains the shared definitions package and the ALU datapath.

package riscv_defines;
  localparam int unsigned WORD_WIDTH   = 32;
  localparam int unsigned ALU_OP_WIDTH = 4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
endpackage

// Combinational ALU; unknown operators yield zero without any error flag.
module alu #(
  parameter int unsigned WORD_WIDTH   = riscv_defines::WORD_WIDTH,
  parameter int unsigned ALU_OP_WIDTH = riscv_defines::ALU_OP_WIDTH
) (
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [WORD_WIDTH-1:0]   operand_a_i,
  input  logic [WORD_WIDTH-1:0]   operand_b_i,
  output logic [WORD_WIDTH-1:0]   result_o
);
  import riscv_defines::*;

  localparam int unsigned SHAMT_W = $clog2(WORD_WIDTH);

  logic [SHAMT_W-1:0] shamt_s;
  assign shamt_s = operand_b_i[SHAMT_W-1:0];

  // Operator decode
  always_comb begin
    result_o = '0;
    case (operator_i)
      ALU_ADD:  result_o = operand_a_i + operand_b_i;
      ALU_SUB:  result_o = operand_a_i - operand_b_i;
      ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
      ALU_OR:   result_o = operand_a_i | operand_b_i;
      ALU_AND:  result_o = operand_a_i & operand_b_i;
      ALU_SLL:  result_o = operand_a_i << shamt_s;
      ALU_SRL:  result_o = operand_a_i >> shamt_s;
      ALU_SRA:  result_o = WORD_WIDTH'($signed(operand_a_i) >>> shamt_s);
      ALU_SLT:  result_o[0] = ($signed(operand_a_i) < $signed(operand_b_i));
      ALU_SLTU: result_o[0] = (operand_a_i < operand_b_i);
      default:  result_o = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int unsigned WORD_WIDTH   = riscv_defines::WORD_WIDTH,
  parameter int unsigned ALU_OP_WIDTH = riscv_defines::ALU_OP_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [2*WORD_WIDTH-1:0]   req_operand_a_i,
  input  logic [2*WORD_WIDTH-1:0]   req_operand_b_i,
  input  logic [2*ALU_OP_WIDTH-1:0] req_operator_i,
  output logic [1:0]                rsp_valid_o,
  input  logic [1:0]                rsp_ready_i,
  output logic [WORD_WIDTH-1:0]     rsp_result_o
);

  logic                    full_q, full_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  logic [WORD_WIDTH-1:0]   result_q, result_d;

  logic                    can_accept_s;
  logic [1:0]              grant_s;
  logic                    accept_s;
  logic                    sel_s;
  logic [WORD_WIDTH-1:0]   op_a_s;
  logic [WORD_WIDTH-1:0]   op_b_s;
  logic [ALU_OP_WIDTH-1:0] op_s;
  logic [WORD_WIDTH-1:0]   alu_result_s;

  // The stage can be refilled in the same cycle its owner drains it.
  assign can_accept_s = !full_q || rsp_ready_i[owner_q];

  // Round-robin grant: a tie goes to the port not granted most recently.
  always_comb begin
    grant_s = 2'b00;
    if (can_accept_s) begin
      case (req_valid_i)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  assign req_ready_o = grant_s;
  assign accept_s    = grant_s[0] | grant_s[1];

  // Datapath select; with no grant the mux parks on last_grant (value unused).
  always_comb begin
    sel_s = last_grant_q;
    if (grant_s[1]) begin
      sel_s = 1'b1;
    end else if (grant_s[0]) begin
      sel_s = 1'b0;
    end else begin
      sel_s = last_grant_q;
    end
  end

  assign op_a_s = sel_s ? req_operand_a_i[WORD_WIDTH +: WORD_WIDTH] : req_operand_a_i[0 +: WORD_WIDTH];
  assign op_b_s = sel_s ? req_operand_b_i[WORD_WIDTH +: WORD_WIDTH] : req_operand_b_i[0 +: WORD_WIDTH];
  assign op_s   = sel_s ? req_operator_i[ALU_OP_WIDTH +: ALU_OP_WIDTH] : req_operator_i[0 +: ALU_OP_WIDTH];

  alu #(
    .WORD_WIDTH  (WORD_WIDTH),
    .ALU_OP_WIDTH(ALU_OP_WIDTH)
  ) u_alu (
    .operator_i (op_s),
    .operand_a_i(op_a_s),
    .operand_b_i(op_b_s),
    .result_o   (alu_result_s)
  );

  // Output stage next state: accept overrides drain.
  always_comb begin
    full_d       = full_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    if (accept_s) begin
      full_d       = 1'b1;
      owner_d      = sel_s;
      last_grant_d = sel_s;
      result_d     = alu_result_s;
    end else if (full_q && rsp_ready_i[owner_q]) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // State registers; last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
    end else begin
      full_q       <= full_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
    end
  end

  assign rsp_valid_o  = {full_q & owner_q, full_q & ~owner_q};
  assign rsp_result_o = result_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between two requesters, for example the execute stage (port 0) and a multi-cycle address/iteration unit (port 1). Each cycle the block grants at most one operation by round-robin over a valid/ready handshake. It registers the ALU result in a single-entry output stage and returns the result to the granting requester, with its own valid/ready handshake. The block sits in the execute stage, between the requesters and the `alu` datapath, and adds exactly one cycle of latency.

## Interface
- `WORD_WIDTH`, default `riscv_defines::WORD_WIDTH` (32): operand and result width.
- `ALU_OP_WIDTH`, default `riscv_defines::ALU_OP_WIDTH`: operator encoding width, passed unchanged to `alu`.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  2  bit r: requester r presents an operation.
- `req_ready_o`  out  2  bit r: requester r's operation is accepted this cycle; combinational.
- `req_operand_a_i`  in  2*WORD_WIDTH  operand A for requester r, in bits [r*WORD_WIDTH +: WORD_WIDTH].
- `req_operand_b_i`  in  2*WORD_WIDTH  operand B, same packing.
- `req_operator_i`  in  2*ALU_OP_WIDTH  ALU operator, packed the same way.
- `rsp_valid_o`  out  2  bit r: a result for requester r is held in the output stage; registered.
- `rsp_ready_i`  in  2  bit r: requester r consumes its result this cycle.
- `rsp_result_o`  out  WORD_WIDTH  registered result, shared by both ports; qualified only by `rsp_valid_o`.

## Operation
- **State.**
  - `full`: output stage occupied.
  - `owner`: 1 bit, the requester owning the stored result.
  - `result_q`: WORD_WIDTH-bit stored result.
  - `last_grant`: 1 bit, the requester granted most recently.
- **can_accept** = `!full || rsp_ready_i[owner]`. The stage may be refilled in the same cycle it drains.
- **Arbitration, only when can_accept:**
  - If exactly one requester is valid, grant it.
  - If both are valid, grant `!last_grant` (round-robin).
  - If none is valid, grant nothing.
- **Ready.** `req_ready_o[r]` = grant[r]. At most one bit is high in any cycle. `req_ready_o` may depend on `req_valid_i` and `rsp_ready_i`. Requesters must not make valid depend on ready.
- **Datapath.** The granted requester's operands and operator are muxed into the single `alu`. When no grant is made, the mux selects port `last_grant`; the value is irrelevant.
- **On accept (valid & ready for r):**
  - `result_q` <= ALU result.
  - `owner` <= r.
  - `full` <= 1.
  - `last_grant` <= r.
- **On drain without accept:** `full` <= 0.
- **Last grant pointer.** `last_grant` changes only on an accepted grant, never on idle cycles.
- **Outputs.** `rsp_valid_o[r]` = `full && owner == r`. `rsp_result_o` = `result_q`.
- **Requester rules (verification assertions):**
  - Payload must stay stable while valid && !ready.
  - Valid may not drop before ready.
- **Operators.** Undefined operators are forwarded unchanged. The result is whatever `alu` produces; no error is flagged.
- **Fairness.** When both requesters hold valid continuously, grants strictly alternate. A waiting requester is granted within 2 accepted operations.
- **Response ordering.** Responses return in grant order; there is one outstanding result total.

## Timing
- **Reset values:**
  - `full`=0, `owner`=0, `last_grant`=1 (port 0 wins the first tie), `result_q`=0.
  - Hence `rsp_valid_o`=2'b00 and `rsp_result_o`=0.
  - `req_ready_o` is combinational: 2'b00 while no request is valid.
- **Latency.** An operation accepted at edge N shows `rsp_valid_o` high and a valid result from edge N+1.
- **Throughput.** One operation per cycle while the owner holds `rsp_ready_i`=1.
- **Backpressure.** While `full && !rsp_ready_i[owner]`:
  - `req_ready_o`=0 for both ports, including the owner.
  - `rsp_valid_o` and `rsp_result_o` hold.
- **Simultaneous drain and accept.** The old result is consumed, the new one is written, and `rsp_valid_o` switches to the new owner without a bubble.
- **Reset mid-operation.** Asserting `rst_i` at any point:
  - Clears the stage immediately (asynchronously); the pending result is discarded and never presented.
  - Restores `last_grant`=1.
- **Ready while full.** `rsp_ready_i` of a non-owner port is ignored.

## Test plan
- **Reset check.** Assert `rst_i` while the output stage is full with owner 1 -> `rsp_valid_o`=00 and `rsp_result_o`=0 immediately. After release, a port-0 ADD 5+3 is granted first and returns 8.
- **Single port.** Port 0 issues ALU_ADD 5,3, then ALU_SUB 5,3, then ALU_SLT 0xFFFFFFFF,1 back-to-back with `rsp_ready_i`=11 -> `req_ready_o[0]` high each cycle. `rsp_result_o` shows 8, 2, 1 on consecutive cycles, one cycle after each accept.
- **Tie arbitration.** Both ports are valid continuously. Port 0 issues ADD 1,1; port 1 issues XOR 0xF0,0xFF -> grants alternate 0,1,0,1. Results alternate 2 and 0x0F, with `rsp_valid_o` alternating 01,10.
- **Backpressure.** Port 1 accepts SLL 1,4, then holds `rsp_ready_i[1]`=0 for 3 cycles while port 0 is valid -> `req_ready_o`=00 for those 3 cycles and `rsp_result_o` stays 16. On release, port 0 is granted in the same cycle and there is no bubble.
- **Fairness after idle.** Port 1 is granted. Then 5 idle cycles. Then both ports are valid -> port 0 is granted first, because `last_grant` is unchanged by the idle cycles.
- **Non-owner ready ignored.** Port 0 result is pending with `rsp_ready_i`=10 -> the stage stays full and the result is 0x…, unchanged until `rsp_ready_i[0]`=1.
